// File: rtl/clk_phase_pkg.sv
// Shared types and constants for the divided-clock phase controller.
// The phase register counts down; 000 is the last phase of a frame.
package clk_phase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_LAST  = 3'b000;
    localparam logic [PHASE_W-1:0] PHASE_FIRST = 3'b111;

    localparam logic [1:0] RATE_DIV2 = 2'd0;
    localparam logic [1:0] RATE_DIV4 = 2'd1;
    localparam logic [1:0] RATE_DIV8 = 2'd2;

    // Reserved encoding 3 falls through to the /8 strobe.
    function automatic logic rate_strobe(
        input logic [1:0] rate,
        input logic       c2,
        input logic       c4,
        input logic       c8
    );
        logic s;
        case (rate)
            RATE_DIV2: s = c2;
            RATE_DIV4: s = c4;
            default:   s = c8;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/clk_phase_ctrl_phase_div.sv
// Down-counting phase register in the /2,/4,/8 generator bit pattern,
// with clear/load/advance controls and registered-state strobe decodes.
module phase_div
    import clk_phase_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic               adv,
    input  logic               active,
    output logic [PHASE_W-1:0] phase,
    output logic               ce_2,
    output logic               ce_4,
    output logic               ce_8
);

    logic [PHASE_W-1:0] ph;
    logic [PHASE_W-1:0] ph_dec;

    // Each bit toggles when all lower bits were 0.
    assign ph_dec = {ph[2] ^ (~ph[1] & ~ph[0]),
                     ph[1] ^ ~ph[0],
                     ~ph[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            ph <= PHASE_LAST;
        end else if (clear) begin
            ph <= PHASE_LAST;
        end else if (load) begin
            ph <= PHASE_FIRST;
        end else if (adv) begin
            ph <= ph_dec;
        end
    end

    assign phase = ph;
    assign ce_2  = active & ph[0];
    assign ce_4  = active & ph[1] & ph[0];
    assign ce_8  = active & ph[2] & ph[1] & ph[0];

endmodule

// File: rtl/clk_phase_ctrl.sv
// Divided-clock domain controller: run/warm-up/drain sequencing and
// frame-aligned rate selection on top of the phase_div generator.
module clk_phase_ctrl
    import clk_phase_pkg::*;
#(
    parameter int WARMUP_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               rate_req,
    input  logic [1:0]         rate_sel,
    output logic [PHASE_W-1:0] phase,
    output logic               ce_2,
    output logic               ce_4,
    output logic               ce_8,
    output logic               ce_sel,
    output logic               frame_start,
    output logic               locked,
    output logic               busy,
    output logic [1:0]         state
);

    localparam int CNT_W = $clog2(WARMUP_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WARMUP_FRAMES);

    state_t           st;
    state_t           st_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             ph_load;
    logic             ph_clr;
    logic             ph_adv;
    logic             at_last;
    logic             boundary;
    logic [1:0]       rate_act;
    logic [1:0]       rate_pend;

    phase_div u_phase_div (
        .clk    (clk),
        .reset  (reset),
        .clear  (ph_clr),
        .load   (ph_load),
        .adv    (ph_adv),
        .active (st != ST_IDLE),
        .phase  (phase),
        .ce_2   (ce_2),
        .ce_4   (ce_4),
        .ce_8   (ce_8)
    );

    assign at_last  = (phase == PHASE_LAST);
    assign cnt_inc  = cnt + CNT_W'(1);
    assign boundary = ph_adv & at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= ST_IDLE;
            cnt <= '0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        ph_load = 1'b0;
        ph_clr  = 1'b0;
        ph_adv  = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (en) begin
                    st_n    = ST_WARMUP;
                    ph_load = 1'b1;
                    cnt_n   = '0;
                end
            end
            ST_WARMUP: begin
                if (!en) begin
                    st_n   = ST_IDLE;
                    ph_clr = 1'b1;
                    cnt_n  = '0;
                end else begin
                    ph_adv = 1'b1;
                    if (at_last) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            st_n = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                ph_adv = 1'b1;
                if (!en) begin
                    st_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    st_n   = ST_RUN;
                    ph_adv = 1'b1;
                end else if (at_last) begin
                    st_n   = ST_IDLE;
                    ph_clr = 1'b1;
                end else begin
                    ph_adv = 1'b1;
                end
            end
        endcase
    end

    // Rate switches only where every strobe restarts, so ce_sel stays whole.
    always_ff @(posedge clk) begin
        if (reset) begin
            rate_act  <= RATE_DIV8;
            rate_pend <= RATE_DIV8;
            busy      <= 1'b0;
        end else if (st == ST_IDLE) begin
            if (rate_req) begin
                rate_act <= rate_sel;
            end
        end else if (ph_clr) begin
            if (rate_req) begin
                rate_act <= rate_sel;
            end else if (busy) begin
                rate_act <= rate_pend;
            end
            busy <= 1'b0;
        end else begin
            if (busy && boundary) begin
                rate_act <= rate_pend;
                busy     <= 1'b0;
            end
            if (rate_req) begin
                rate_pend <= rate_sel;
                busy      <= 1'b1;
            end
        end
    end

    assign ce_sel      = rate_strobe(rate_act, ce_2, ce_4, ce_8);
    assign frame_start = ce_8;
    assign locked      = (st == ST_RUN) || (st == ST_DRAIN);
    assign state       = st;

endmodule
